// File: rtl/regfile_operand_collector_pkg.sv
// Shared types and constants for the register-file operand collector.
// The source-count-to-pending-mask helper is shared by all collector variants.
package regfile_operand_collector_pkg;

    localparam int NSRC_WIDTH = 2;
    localparam int MAX_SRC    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    // One pending bit per requested source, starting at source 0.
    function automatic logic [MAX_SRC-1:0] nsrc_to_mask(input logic [NSRC_WIDTH-1:0] nsrc);
        case (nsrc)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/regfile_operand_collector_src_pick.sv
// Picks the first and second set bits of the pending-source mask.
// Port A serves the first pick and port B serves the second.
module collector_src_pick
    import regfile_operand_collector_pkg::*;
(
    input  logic [MAX_SRC-1:0]    mask,
    output logic [NSRC_WIDTH-1:0] first_idx,
    output logic                  first_vld,
    output logic [NSRC_WIDTH-1:0] second_idx,
    output logic                  second_vld
);

    // NOTE: every output gets a default before the loop; otherwise a path that leaves one unassigned infers a latch.
    always_comb begin
        first_idx  = '0;
        first_vld  = 1'b0;
        second_idx = '0;
        second_vld = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (mask[i]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = NSRC_WIDTH'(i);
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = NSRC_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_operand_collector.sv
// Operand collector: fetches up to three source operands over the two regfile ports
// and holds them for issue. Writeback owns port B whenever it is valid.
module regfile_operand_collector
    import regfile_operand_collector_pkg::*;
#(
    parameter int RAM_SIZE    = 1024,
    parameter int RAM_A_WIDTH = 10,
    parameter int RAM_D_WIDTH = 8,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NSRC_WIDTH-1:0]  req_nsrc,
    input  logic [RAM_A_WIDTH-1:0] req_src0,
    input  logic [RAM_A_WIDTH-1:0] req_src1,
    input  logic [RAM_A_WIDTH-1:0] req_src2,
    input  logic [TAG_WIDTH-1:0]   req_tag,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RAM_D_WIDTH-1:0] out_op0,
    output logic [RAM_D_WIDTH-1:0] out_op1,
    output logic [RAM_D_WIDTH-1:0] out_op2,
    output logic [TAG_WIDTH-1:0]   out_tag,

    input  logic                   wb_valid,
    input  logic [RAM_A_WIDTH-1:0] wb_addr,
    input  logic [RAM_D_WIDTH-1:0] wb_data,

    output logic [RAM_A_WIDTH-1:0] rf_addr_a,
    output logic [RAM_A_WIDTH-1:0] rf_addr_b,
    output logic [RAM_D_WIDTH-1:0] rf_din_a,
    output logic [RAM_D_WIDTH-1:0] rf_din_b,
    output logic                   rf_we_a,
    output logic                   rf_we_b,
    input  logic [RAM_D_WIDTH-1:0] rf_dout_a,
    input  logic [RAM_D_WIDTH-1:0] rf_dout_b
);

    // Out-of-range sources are resolved by the regfile returning 0; the collector only
    // needs the depth to be addressable.
    if (RAM_SIZE > (1 << RAM_A_WIDTH)) begin : g_bad_size
        $error("regfile_operand_collector: RAM_SIZE exceeds the RAM_A_WIDTH address space");
    end

    state_t                 state_q, state_d;
    logic [MAX_SRC-1:0]     pend_q, pend_d;
    logic [RAM_A_WIDTH-1:0] src_q [MAX_SRC];
    logic [RAM_D_WIDTH-1:0] op_q  [MAX_SRC];
    logic [TAG_WIDTH-1:0]   tag_q;

    logic [NSRC_WIDTH-1:0]  first_idx, second_idx;
    logic                   first_vld, second_vld;
    logic [MAX_SRC-1:0]     cap_a, cap_b;
    logic [RAM_A_WIDTH-1:0] rd_a_addr, rd_b_addr;
    logic                   accept;

    collector_src_pick u_pick (
        .mask       (pend_q),
        .first_idx  (first_idx),
        .first_vld  (first_vld),
        .second_idx (second_idx),
        .second_vld (second_vld)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        cap_a     = '0;
        cap_b     = '0;
        rd_a_addr = '0;
        rd_b_addr = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    pend_d  = nsrc_to_mask(req_nsrc);
                    state_d = (req_nsrc != '0) ? READ : DONE;
                end
            end

            READ: begin
                // A writeback cycle steals port B, so only the port-A source retires.
                for (int i = 0; i < MAX_SRC; i++) begin
                    if (first_vld && first_idx == NSRC_WIDTH'(i)) begin
                        cap_a[i]  = 1'b1;
                        rd_a_addr = src_q[i];
                    end
                    if (!wb_valid && second_vld && second_idx == NSRC_WIDTH'(i)) begin
                        cap_b[i]  = 1'b1;
                        rd_b_addr = src_q[i];
                    end
                end
                pend_d = pend_q & ~(cap_a | cap_b);
                if (pend_d == '0) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            tag_q   <= '0;
            // NOTE: the operand array is reset because unused and dropped operands must read back as 0.
            for (int i = 0; i < MAX_SRC; i++) begin
                src_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (accept) begin
                tag_q    <= req_tag;
                src_q[0] <= req_src0;
                src_q[1] <= req_src1;
                src_q[2] <= req_src2;
                for (int i = 0; i < MAX_SRC; i++) begin
                    op_q[i] <= '0;
                end
            end
            for (int i = 0; i < MAX_SRC; i++) begin
                if (cap_a[i]) begin
                    op_q[i] <= rf_dout_a;
                end else if (cap_b[i]) begin
                    op_q[i] <= rf_dout_b;
                end
            end
        end
    end

    assign out_op0   = op_q[0];
    assign out_op1   = op_q[1];
    assign out_op2   = op_q[2];
    assign out_tag   = tag_q;

    assign rf_addr_a = rd_a_addr;
    assign rf_we_a   = 1'b0;
    assign rf_din_a  = '0;

    assign rf_we_b   = wb_valid;
    assign rf_din_b  = wb_data;
    assign rf_addr_b = wb_valid ? wb_addr : rd_b_addr;

endmodule

// File: tb/tb_regfile_operand_collector.sv
// Directed bench for regfile_operand_collector with a behavioural dual-port regfile
// (port-B write, combinational reads, write-to-port-A forwarding, 0 beyond the depth).
module tb_regfile_operand_collector;

    localparam int SIZE = 1024;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int TW   = 4;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_nsrc;
    logic [AW-1:0] req_src0, req_src1, req_src2;
    logic [TW-1:0] req_tag;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_op0, out_op1, out_op2;
    logic [TW-1:0] out_tag;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_addr_a, rf_addr_b;
    logic [DW-1:0] rf_din_a, rf_din_b;
    logic          rf_we_a, rf_we_b;
    logic [DW-1:0] rf_dout_a, rf_dout_b;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] wr_mem [SIZE];
    bit            wr_vld [SIZE];

    regfile_operand_collector #(
        .RAM_SIZE    (SIZE),
        .RAM_A_WIDTH (AW),
        .RAM_D_WIDTH (DW),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_nsrc  (req_nsrc),
        .req_src0  (req_src0),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .req_tag   (req_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op0   (out_op0),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_tag   (out_tag),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rf_addr_a (rf_addr_a),
        .rf_addr_b (rf_addr_b),
        .rf_din_a  (rf_din_a),
        .rf_din_b  (rf_din_b),
        .rf_we_a   (rf_we_a),
        .rf_we_b   (rf_we_b),
        .rf_dout_a (rf_dout_a),
        .rf_dout_b (rf_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile contents before any writeback.
    function automatic logic [DW-1:0] init_val(input logic [9:0] a);
        case (a)
            10'd5:   return 8'h11;
            10'd6:   return 8'h22;
            10'd7:   return 8'h33;
            10'd9:   return 8'h44;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rf_we_b && rf_addr_b < AW'(SIZE)) begin
            wr_mem[rf_addr_b[9:0]] <= rf_din_b;
            wr_vld[rf_addr_b[9:0]] <= 1'b1;
        end
    end

    always_comb begin
        rf_dout_a = '0;
        if (rf_we_b && rf_addr_b == rf_addr_a)
            rf_dout_a = rf_din_b;
        else if (rf_addr_a < AW'(SIZE))
            rf_dout_a = wr_vld[rf_addr_a[9:0]] ? wr_mem[rf_addr_a[9:0]] : init_val(rf_addr_a[9:0]);
    end

    always_comb begin
        rf_dout_b = '0;
        if (rf_addr_b < AW'(SIZE))
            rf_dout_b = wr_vld[rf_addr_b[9:0]] ? wr_mem[rf_addr_b[9:0]] : init_val(rf_addr_b[9:0]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] n, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2, input logic [TW-1:0] t);
        req_valid = 1'b1;
        req_nsrc  = n;
        req_src0  = s0;
        req_src1  = s1;
        req_src2  = s2;
        req_tag   = t;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_nsrc = '0; req_src0 = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tag",   out_tag,   0);
        check("rst_op0",       out_op0,   0);
        check("rst_addr_a",    rf_addr_a, 0);
        check("rst_addr_b",    rf_addr_b, 0);
        check("rst_we_a",      rf_we_a,   0);
        check("rst_din_a",     rf_din_a,  0);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1 rst = 1'b1;

        // Three sources, no writeback.
        step();
        req(2'd3, 11'd5, 11'd6, 11'd7, 4'hA); out_ready = 1'b1; #1;
        check("t1_req_ready", req_ready, 1);
        step(); req_valid = 1'b0; #1;
        check("t1_r1_addr_a", rf_addr_a, 5);
        check("t1_r1_addr_b", rf_addr_b, 6);
        check("t1_r1_we_b",   rf_we_b,   0);
        check("t1_r1_valid",  out_valid, 0);
        check("t1_r1_ready",  req_ready, 0);
        step();
        check("t1_r2_addr_a", rf_addr_a, 7);
        check("t1_r2_addr_b", rf_addr_b, 0);
        check("t1_r2_valid",  out_valid, 0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_op0",   out_op0,   8'h11);
        check("t1_op1",   out_op1,   8'h22);
        check("t1_op2",   out_op2,   8'h33);
        check("t1_tag",   out_tag,   4'hA);
        step();
        check("t1_drop_valid", out_valid, 0);
        check("t1_idle_ready", req_ready, 1);

        // Same request with writeback stealing port B for two rounds.
        req(2'd3, 11'd5, 11'd6, 11'd7, 4'hB); #1;
        step(); req_valid = 1'b0; wb_valid = 1'b1; wb_addr = 11'd100; wb_data = 8'h5A; #1;
        check("t2_r1_we_b",   rf_we_b,   1);
        check("t2_r1_addr_b", rf_addr_b, 100);
        check("t2_r1_din_b",  rf_din_b,  8'h5A);
        check("t2_r1_addr_a", rf_addr_a, 5);
        step();
        check("t2_r2_addr_a", rf_addr_a, 6);
        check("t2_r2_addr_b", rf_addr_b, 100);
        check("t2_r2_valid",  out_valid, 0);
        step(); wb_valid = 1'b0; #1;
        check("t2_r3_addr_a", rf_addr_a, 7);
        check("t2_r3_we_b",   rf_we_b,   0);
        check("t2_r3_valid",  out_valid, 0);
        step();
        check("t2_valid", out_valid, 1);
        check("t2_op0",   out_op0,   8'h11);
        check("t2_op1",   out_op1,   8'h22);
        check("t2_op2",   out_op2,   8'h33);
        check("t2_tag",   out_tag,   4'hB);
        check("t2_mem100", {23'd0, wr_vld[100], wr_mem[100]}, 32'h15A);
        step();
        check("t2_drop_valid", out_valid, 0);

        // Single source colliding with a writeback to the same register.
        req(2'd1, 11'd9, 11'd5, 11'd6, 4'h1); #1;
        step(); req_valid = 1'b0; wb_valid = 1'b1; wb_addr = 11'd9; wb_data = 8'hEE; #1;
        check("t3_addr_a", rf_addr_a, 9);
        step(); wb_valid = 1'b0; #1;
        check("t3_valid", out_valid, 1);
        check("t3_op0",   out_op0,   8'hEE);
        check("t3_op1",   out_op1,   0);
        check("t3_op2",   out_op2,   0);
        check("t3_tag",   out_tag,   4'h1);
        step();
        check("t3_drop_valid", out_valid, 0);

        // No sources; hold under back-pressure while a new request is ignored.
        req(2'd0, 11'd5, 11'd6, 11'd7, 4'h3); out_ready = 1'b0; #1;
        step(); req(2'd3, 11'd5, 11'd6, 11'd7, 4'h5); #1;
        check("t4_valid", out_valid, 1);
        check("t4_tag",   out_tag,   4'h3);
        check("t4_ops",   {out_op0, out_op1, out_op2}, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_tag",   out_tag,   4'h3);
            check("t4_hold_ready", req_ready, 0);
            check("t4_hold_ops",   {out_op0, out_op1, out_op2}, 0);
        end
        req_valid = 1'b0; out_ready = 1'b1;
        step();
        check("t4_drop_valid", out_valid, 0);
        check("t4_idle_ready", req_ready, 1);

        // Out-of-range second source.
        req(2'd2, 11'd7, 11'd2000, 11'd0, 4'h6); #1;
        step(); req_valid = 1'b0; #1;
        check("t5_addr_b", rf_addr_b, 2000);
        step();
        check("t5_valid", out_valid, 1);
        check("t5_op0",   out_op0,   8'h33);
        check("t5_op1",   out_op1,   0);
        check("t5_op2",   out_op2,   0);
        check("t5_tag",   out_tag,   4'h6);
        step();

        // Reset in the middle of a READ, then a fresh request.
        req(2'd3, 11'd5, 11'd6, 11'd7, 4'hC); #1;
        step(); req_valid = 1'b0; #1;
        rst = 1'b0; #1;
        check("t6_rst_valid",  out_valid, 0);
        check("t6_rst_addr_a", rf_addr_a, 0);
        check("t6_rst_addr_b", rf_addr_b, 0);
        check("t6_rst_tag",    out_tag,   0);
        check("t6_rst_op0",    out_op0,   0);
        step(); rst = 1'b1; #1;
        check("t6_post_valid",  out_valid, 0);
        check("t6_post_ready",  req_ready, 1);
        check("t6_post_addr_a", rf_addr_a, 0);
        req(2'd2, 11'd6, 11'd7, 11'd0, 4'h9); #1;
        step(); req_valid = 1'b0; #1;
        check("t6_r1_addr_a", rf_addr_a, 6);
        check("t6_r1_addr_b", rf_addr_b, 7);
        step();
        check("t6_valid", out_valid, 1);
        check("t6_op0",   out_op0,   8'h22);
        check("t6_op1",   out_op1,   8'h33);
        check("t6_op2",   out_op2,   0);
        check("t6_tag",   out_tag,   4'h9);
        step();
        check("t6_drop_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
